// File: rtl/dmem_responder_if.sv
// Request/response bus between the pipeline memory stage and dmem_responder.
// The master drives the request fields; the slave returns rdata/ack/err/busy.
interface dmem_responder_if;
    logic        req;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;
    logic        err;
    logic        busy;

    modport master (
        output req, we, funct3, addr, wdata,
        input  rdata, ack, err, busy
    );

    modport slave (
        input  req, we, funct3, addr, wdata,
        output rdata, ack, err, busy
    );
endinterface

// File: rtl/dmem_responder.sv
// RV32I data-memory responder: word RAM with byte/half/word load-store rules and req/ack wait states.
// Define DMEM_MISALIGN_ERR_EN to flag misaligned H/W accesses instead of forcing them aligned.
module dmem_responder #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic           clk,
    input  logic           reset,
    dmem_responder_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [3:0] LAST_WAIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, state_d;
    logic [3:0] cnt, cnt_d;
    logic       accept, enter_resp, armed;

    logic             we_q;
    logic [2:0]       f3_q;
    logic [IDX_W+1:0] addr_q;
    logic [31:0]      wdata_q;

    logic             op_we;
    logic [2:0]       op_f3;
    logic [IDX_W+1:0] op_addr;
    logic [31:0]      op_wdata;

    logic             illegal, bad, mem_wr;
    logic [IDX_W-1:0] idx;
    logic [3:0]       lane_mask;
    logic [31:0]      lane_data, word, load_val;
    logic [7:0]       byte_sel;
    logic [15:0]      half_sel;
    logic [31:0]      rdata_q;
    logic             err_q;

    logic [31:0] mem [DEPTH];

    // armed drops asynchronously with reset so nothing is accepted or written while reset is high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) armed <= 1'b0;
        else       armed <= 1'b1;
    end

    assign accept = (state == IDLE) && bus.req && armed;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        enter_resp = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    cnt_d = 4'd0;
                    if (WAIT_STATES == 0) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == LAST_WAIT) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                    cnt_d      = 4'd0;
                end else begin
                    cnt_d = cnt + 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // With zero wait states the RESP-entry edge is the accept edge, so the live inputs are used.
    assign op_we    = (state == IDLE) ? bus.we               : we_q;
    assign op_f3    = (state == IDLE) ? bus.funct3           : f3_q;
    assign op_addr  = (state == IDLE) ? bus.addr[IDX_W+1:0]  : addr_q;
    assign op_wdata = (state == IDLE) ? bus.wdata            : wdata_q;

    assign idx = op_addr[IDX_W+1:2];

    always_comb begin
        illegal = (op_f3 == 3'b011) || (op_f3 == 3'b110) || (op_f3 == 3'b111) ||
                  (op_we && op_f3[2]);
`ifdef DMEM_MISALIGN_ERR_EN
        bad = illegal ||
              ((op_f3[1:0] == 2'b01) && op_addr[0]) ||
              ((op_f3[1:0] == 2'b10) && (op_addr[1:0] != 2'b00));
`else
        bad = illegal;
`endif
    end

    // Lane selection ignores the low address bits a half/word cannot use, forcing alignment.
    always_comb begin
        lane_mask = 4'b1111;
        lane_data = op_wdata;
        unique case (op_f3[1:0])
            2'b00: begin
                lane_mask = 4'b0001 << op_addr[1:0];
                lane_data = {4{op_wdata[7:0]}};
            end
            2'b01: begin
                lane_mask = op_addr[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{op_wdata[15:0]}};
            end
            default: begin
                lane_mask = 4'b1111;
                lane_data = op_wdata;
            end
        endcase
    end

    always_comb begin
        word     = mem[idx];
        byte_sel = word[{op_addr[1:0], 3'b000} +: 8];
        half_sel = op_addr[1] ? word[31:16] : word[15:0];
        unique case (op_f3)
            F3_B:    load_val = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    load_val = {{16{half_sel[15]}}, half_sel};
            F3_BU:   load_val = {24'd0, byte_sel};
            F3_HU:   load_val = {16'd0, half_sel};
            default: load_val = word;
        endcase
    end

    assign mem_wr = enter_resp && op_we && !bad;

    // NOTE: the RAM array has no reset; clearing it would prevent mapping onto memory macros.
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            for (int l = 0; l < 4; l++) begin
                if (lane_mask[l]) mem[idx][8*l +: 8] <= lane_data[8*l +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                we_q    <= bus.we;
                f3_q    <= bus.funct3;
                addr_q  <= bus.addr[IDX_W+1:0];
                wdata_q <= bus.wdata;
            end
            if (enter_resp) begin
                err_q <= bad;
                if (!op_we && !bad) rdata_q <= load_val;
            end
        end
    end

    assign bus.rdata = rdata_q;
    assign bus.ack   = (state == RESP);
    assign bus.err   = (state == RESP) && err_q;
    assign bus.busy  = (state != IDLE);
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (0 and 3 wait states) checked against a byte-addressed model.
module tb_dmem_responder;
    logic clk = 1'b0;
    logic rst0, rst1;
    always #5 clk = ~clk;

    dmem_responder_if b0();
    dmem_responder_if b1();

    dmem_responder #(.DEPTH(1024), .WAIT_STATES(0)) u0 (.clk(clk), .reset(rst0), .bus(b0.slave));
    dmem_responder #(.DEPTH(1024), .WAIT_STATES(3)) u1 (.clk(clk), .reset(rst1), .bus(b1.slave));

    int errors = 0;
    int checks = 0;

    // Reference: byte memory per instance (4 KiB = 1024 words) and last load result.
    logic [7:0]  mb   [2][4096];
    logic [31:0] m_rd [2];

    function automatic int ws(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int d, input logic r, input logic w, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] wd);
        if (d == 0) begin
            b0.req = r; b0.we = w; b0.funct3 = f; b0.addr = a; b0.wdata = wd;
        end else begin
            b1.req = r; b1.we = w; b1.funct3 = f; b1.addr = a; b1.wdata = wd;
        end
    endtask

    function automatic logic [31:0] rd_of(input int d);
        return (d == 0) ? b0.rdata : b1.rdata;
    endfunction
    function automatic logic ack_of(input int d);
        return (d == 0) ? b0.ack : b1.ack;
    endfunction
    function automatic logic err_of(input int d);
        return (d == 0) ? b0.err : b1.err;
    endfunction
    function automatic logic busy_of(input int d);
        return (d == 0) ? b0.busy : b1.busy;
    endfunction

    function automatic void model(input int d, input logic w, input logic [2:0] f,
                                  input logic [31:0] a, input logic [31:0] wd, output logic e);
        int size, base, sh;
        logic [31:0] v;
        logic illegal;
        size    = 1 << f[1:0];
        illegal = (f[1:0] == 2'b11) || (f[2:1] == 2'b11) || (w && f[2]);
        e       = illegal;
`ifdef DMEM_MISALIGN_ERR_EN
        if (size > 1 && (int'(a[11:0]) % size) != 0) e = 1'b1;
`endif
        if (e) return;
        base = int'(a[11:0]) & ~(size - 1);
        if (w) begin
            for (int i = 0; i < size; i++) mb[d][base + i] = wd[8*i +: 8];
        end else begin
            v = 32'd0;
            for (int i = 0; i < size; i++) v = v | (32'(mb[d][base + i]) << (8 * i));
            if (!f[2] && size < 4) begin
                sh = 32 - 8 * size;
                v  = 32'($signed(v << sh) >>> sh);
            end
            m_rd[d] = v;
        end
    endfunction

    task automatic txn(input string tag, input int d, input logic w, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] wd, input bit poke,
                       output logic [31:0] rd, output logic er);
        int cyc, busy_n;
        bit got;
        @(negedge clk);
        drive(d, 1'b1, w, f, a, wd);
        cyc = 0; busy_n = 0; got = 0;
        rd = 32'd0; er = 1'b0;
        while (!got && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1 && poke) drive(d, 1'b1, ~w, f ^ 3'b001, a ^ 32'h0000_0FF4, ~wd);
            if (busy_of(d)) busy_n++;
            if (ack_of(d)) begin
                got = 1;
                rd  = rd_of(d);
                er  = err_of(d);
            end
        end
        drive(d, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        check({tag, "_lat"}, got ? 32'(cyc) : 32'hFFFF_FFFF, 32'(ws(d) + 1));
        check({tag, "_busy"}, 32'(busy_n), 32'(ws(d) + 1));
        @(posedge clk); #1;
        check({tag, "_ackpulse"}, {30'd0, ack_of(d), busy_of(d)}, 32'd0);
    endtask

    task automatic op(input string tag, input int d, input logic w, input logic [2:0] f,
                      input logic [31:0] a, input logic [31:0] wd, input bit poke,
                      output logic [31:0] rd, output logic er);
        logic e_exp;
        model(d, w, f, a, wd, e_exp);
        txn(tag, d, w, f, a, wd, poke, rd, er);
        check({tag, "_err"}, 32'(er), 32'(e_exp));
        check({tag, "_rdata"}, rd, m_rd[d]);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          acks;
        logic        w;
        logic [2:0]  f;
        logic [31:0] a;

        drive(0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        rst0 = 1'b1; rst1 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst0_rdata", b0.rdata, 32'd0);
        check("rst0_flags", {29'd0, b0.ack, b0.err, b0.busy}, 32'd0);
        check("rst1_rdata", b1.rdata, 32'd0);
        check("rst1_flags", {29'd0, b1.ack, b1.err, b1.busy}, 32'd0);
        @(negedge clk);
        rst0 = 1'b0; rst1 = 1'b0;
        m_rd[0] = 32'd0; m_rd[1] = 32'd0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 64; i++) op("init0", 0, 1'b1, 3'b010, 32'(i * 4), $urandom, 1'b0, rd, er);
        for (int i = 0; i < 8; i++)  op("init1", 1, 1'b1, 3'b010, 32'(i * 4), $urandom, 1'b0, rd, er);

        op("sw10", 0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, rd, er);
        op("lw10", 0, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, rd, er);
        check("lw10_lit", rd, 32'hDEADBEEF);

        op("sb11", 0, 1'b1, 3'b000, 32'h11, 32'h80, 1'b0, rd, er);
        op("lb11", 0, 1'b0, 3'b000, 32'h11, 32'h0, 1'b0, rd, er);
        check("lb11_lit", rd, 32'hFFFFFF80);
        op("lbu11", 0, 1'b0, 3'b100, 32'h11, 32'h0, 1'b0, rd, er);
        check("lbu11_lit", rd, 32'h00000080);
        op("lw10b", 0, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, rd, er);
        check("lw10b_lit", rd, 32'hDEAD80EF);

        op("sh22", 0, 1'b1, 3'b001, 32'h22, 32'h00009ABC, 1'b0, rd, er);
        op("lh22", 0, 1'b0, 3'b001, 32'h22, 32'h0, 1'b0, rd, er);
        check("lh22_lit", rd, 32'hFFFF9ABC);
        op("lhu22", 0, 1'b0, 3'b101, 32'h22, 32'h0, 1'b0, rd, er);
        check("lhu22_lit", rd, 32'h00009ABC);
        op("lw20", 0, 1'b0, 3'b010, 32'h20, 32'h0, 1'b0, rd, er);
        check("lw20_hi", {16'd0, rd[31:16]}, 32'h00009ABC);

        op("ws3_lw", 1, 1'b0, 3'b010, 32'h04, 32'h0, 1'b1, rd, er);
        op("ws3_sw_poke", 1, 1'b1, 3'b010, 32'h0C, 32'h55AA_33CC, 1'b1, rd, er);
        op("ws3_lw_back", 1, 1'b0, 3'b010, 32'h0C, 32'h0, 1'b0, rd, er);
        check("ws3_lw_back_lit", rd, 32'h55AA_33CC);

        op("lw13", 0, 1'b0, 3'b010, 32'h13, 32'h0, 1'b0, rd, er);
`ifdef DMEM_MISALIGN_ERR_EN
        check("lw13_err_lit", 32'(er), 32'd1);
`else
        check("lw13_lit", rd, 32'hDEAD80EF);
`endif
        op("f3_011", 0, 1'b0, 3'b011, 32'h10, 32'h0, 1'b0, rd, er);
        check("f3_011_err_lit", 32'(er), 32'd1);
        op("sbu_store", 1, 1'b1, 3'b100, 32'h08, 32'h12, 1'b0, rd, er);
        check("sbu_store_err_lit", 32'(er), 32'd1);

        op("sw1000", 0, 1'b1, 3'b010, 32'h1000, 32'hCAFEF00D, 1'b0, rd, er);
        op("lw0_alias", 0, 1'b0, 3'b010, 32'h0, 32'h0, 1'b0, rd, er);
        check("lw0_alias_lit", rd, 32'hCAFEF00D);

        // Store interrupted by reset while waiting: must be dropped without an ack.
        @(negedge clk);
        drive(1, 1'b1, 1'b1, 3'b010, 32'h08, 32'h12345678);
        @(posedge clk); #1;
        check("rstmid_busy_accept", 32'(busy_of(1)), 32'd1);
        @(posedge clk); #1;
        rst1 = 1'b1;
        drive(1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        #1;
        check("rstmid_busy_clear", 32'(busy_of(1)), 32'd0);
        check("rstmid_rdata_clear", rd_of(1), 32'd0);
        @(negedge clk);
        rst1 = 1'b0;
        m_rd[1] = 32'd0;
        acks = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (ack_of(1)) acks++;
        end
        check("rstmid_no_ack", 32'(acks), 32'd0);
        op("rstmid_reload", 1, 1'b0, 3'b010, 32'h08, 32'h0, 1'b0, rd, er);

        for (int i = 0; i < 80; i++) begin
            w = 1'($urandom);
            f = 3'($urandom_range(0, 7));
            a = ($urandom & 32'hFFFF_F000) | ($urandom & 32'h0000_00FF);
            op("rand0", 0, w, f, a, $urandom, 1'($urandom), rd, er);
        end
        for (int i = 0; i < 20; i++) begin
            w = 1'($urandom);
            f = 3'($urandom_range(0, 7));
            a = ($urandom & 32'hFFFF_F000) | ($urandom & 32'h0000_001F);
            op("rand1", 1, w, f, a, $urandom, 1'($urandom), rd, er);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
